collision_manager: RTL and testbench

Parametrised per-frame collision manager for the Galaga datapath; it sits between the sprite "on" flags and the colour mapper and game controller. It accumulates pixel-level overlaps within each frame into per-object collision flags, tracks enemy hit points and per-enemy explosion timers across frames, and queues enemy-kill events for the score logic through a valid/ready event FIFO.

---
 rtl/collision_manager.sv | 266 ++++++++++++++++++++++++++
 tb/tb_collision_manager.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/collision_manager.sv
// collision_manager: per-frame collision accumulation, enemy hit-point and explosion
// tracking, and a kill-event queue for the score logic.
// Optional build macro: COLL_EVENT_FIFO_EN adds the kill-event FIFO with valid/ready handshake.
module collision_manager #(
  parameter int unsigned NP          = 2,
  parameter int unsigned NE          = 8,
  parameter int unsigned NPE         = 2,
  parameter int unsigned HP_W        = 2,
  parameter int unsigned EXPL_FRAMES = 16,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                    pixel_clk,
  input  logic                    Reset,
  input  logic                    frame_clk,
  input  logic                    ShipOn,
  input  logic [NP-1:0]           ProjOn,
  input  logic [NE-1:0]           EShipOn,
  input  logic [NE*NPE-1:0]       EProjOn,
  input  logic [NE-1:0]           spawn,
  input  logic [HP_W-1:0]         hp_init,
  output logic                    ShipColl,
  output logic [NP-1:0]           ProjColl,
  output logic [NE*NPE-1:0]       EProjColl,
  output logic [NE-1:0]           alive,
  output logic [NE-1:0]           ExplodeOn,
  output logic                    evt_valid,
  output logic [$clog2(NE)-1:0]   evt_idx,
  input  logic                    evt_ready,
  output logic                    evt_ovf
);
  localparam int unsigned IW  = $clog2(NE);
  localparam int unsigned TW  = 8;
  localparam int unsigned EPW = NE * NPE;

  typedef enum logic {S_IDLE, S_SCAN} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   k_q, k_d;
  logic            fc_q, fc_d;
  logic            fe;
  logic [NE-1:0]   es;
  logic            ship_sig;
  logic [NP-1:0]   proj_sig;
  logic [NE-1:0]   esh_sig;
  logic [EPW-1:0]  eproj_sig;
  logic            acc_ship_q, acc_ship_d;
  logic [NP-1:0]   acc_proj_q, acc_proj_d;
  logic [NE-1:0]   acc_esh_q, acc_esh_d;
  logic [EPW-1:0]  acc_eproj_q, acc_eproj_d;
  logic            ship_coll_q, ship_coll_d;
  logic [NP-1:0]   proj_coll_q, proj_coll_d;
  logic [EPW-1:0]  eproj_coll_q, eproj_coll_d;
  logic [NE-1:0]   snap_q, snap_d;
  logic [NE-1:0]   alive_q, alive_d;
  logic [NE-1:0]   explode_q, explode_d;
  logic [HP_W-1:0] hp_q [NE];
  logic [HP_W-1:0] hp_d [NE];
  logic [TW-1:0]   timer_q [NE];
  logic [TW-1:0]   timer_d [NE];
  logic            ovf_q, ovf_d;
  logic            kill_c;
  logic [IW-1:0]   kill_idx_c;
  logic            missed_scan_c;
  logic            drop_c;

  // Frame edge detect, per-pixel hit terms, per-frame accumulation and output capture
  always_comb begin
    fc_d      = frame_clk;
    fe        = frame_clk & ~fc_q;
    es        = EShipOn & alive_q;
    ship_sig  = ShipOn & ((|EProjOn) | (|es));
    proj_sig  = ProjOn & {NP{|es}};
    esh_sig   = es & {NE{|ProjOn}};
    eproj_sig = EProjOn & {EPW{ShipOn}};
    acc_ship_d   = acc_ship_q | ship_sig;
    acc_proj_d   = acc_proj_q | proj_sig;
    acc_esh_d    = acc_esh_q | esh_sig;
    acc_eproj_d  = acc_eproj_q | eproj_sig;
    ship_coll_d  = ship_coll_q;
    proj_coll_d  = proj_coll_q;
    eproj_coll_d = eproj_coll_q;
    if (fe) begin
      // reload with this cycle's hits so no pixel straddling the edge is lost
      acc_ship_d   = ship_sig;
      acc_proj_d   = proj_sig;
      acc_esh_d    = esh_sig;
      acc_eproj_d  = eproj_sig;
      ship_coll_d  = acc_ship_q;
      proj_coll_d  = acc_proj_q;
      eproj_coll_d = acc_eproj_q;
    end
    // a running scan keeps working on the snapshot it started with
    snap_d = (fe && (state_q == S_IDLE)) ? acc_esh_q : snap_q;
  end

  // Scan FSM plus hit-point, alive and explosion-timer updates
  always_comb begin
    state_d       = state_q;
    k_d           = k_q;
    alive_d       = alive_q;
    hp_d          = hp_q;
    timer_d       = timer_q;
    kill_c        = 1'b0;
    kill_idx_c    = '0;
    missed_scan_c = 1'b0;
    if (fe) begin
      for (int unsigned i = 0; i < NE; i++) begin
        if (timer_q[i] != '0) timer_d[i] = timer_q[i] - TW'(1);
      end
    end
    case (state_q)
      S_IDLE: begin
        if (fe) begin
          state_d = S_SCAN;
          k_d     = '0;
        end
      end
      S_SCAN: begin
        missed_scan_c = fe;
        if (snap_q[k_q] && alive_q[k_q]) begin
          if (hp_q[k_q] > HP_W'(1)) begin
            hp_d[k_q] = hp_q[k_q] - HP_W'(1);
          end else begin
            hp_d[k_q]    = '0;
            alive_d[k_q] = 1'b0;
            timer_d[k_q] = TW'(EXPL_FRAMES);
            kill_c       = 1'b1;
            kill_idx_c   = k_q;
          end
        end
        if (k_q == IW'(NE - 1)) state_d = S_IDLE;
        else                    k_d     = k_q + IW'(1);
      end
      default: state_d = S_IDLE;
    endcase
    // spawn overrides everything for its index, including a same-cycle kill
    for (int unsigned i = 0; i < NE; i++) begin
      if (spawn[i]) begin
        alive_d[i] = 1'b1;
        hp_d[i]    = (hp_init == '0) ? HP_W'(1) : hp_init;
        timer_d[i] = '0;
        if (kill_c && (kill_idx_c == IW'(i))) kill_c = 1'b0;
      end
    end
    for (int unsigned i = 0; i < NE; i++) begin
      explode_d[i] = (timer_d[i] != '0);
    end
  end

  // Sticky overflow: missed scans, plus dropped events when the FIFO is built
  always_comb begin
    ovf_d = ovf_q | missed_scan_c | drop_c;
  end

  // Core state registers
  always_ff @(posedge pixel_clk) begin
    if (Reset) begin
      state_q      <= S_IDLE;
      k_q          <= '0;
      fc_q         <= 1'b0;
      acc_ship_q   <= 1'b0;
      acc_proj_q   <= '0;
      acc_esh_q    <= '0;
      acc_eproj_q  <= '0;
      ship_coll_q  <= 1'b0;
      proj_coll_q  <= '0;
      eproj_coll_q <= '0;
      snap_q       <= '0;
      alive_q      <= '0;
      explode_q    <= '0;
      ovf_q        <= 1'b0;
      for (int unsigned i = 0; i < NE; i++) begin
        hp_q[i]    <= '0;
        timer_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      fc_q         <= fc_d;
      acc_ship_q   <= acc_ship_d;
      acc_proj_q   <= acc_proj_d;
      acc_esh_q    <= acc_esh_d;
      acc_eproj_q  <= acc_eproj_d;
      ship_coll_q  <= ship_coll_d;
      proj_coll_q  <= proj_coll_d;
      eproj_coll_q <= eproj_coll_d;
      snap_q       <= snap_d;
      alive_q      <= alive_d;
      explode_q    <= explode_d;
      ovf_q        <= ovf_d;
      hp_q         <= hp_d;
      timer_q      <= timer_d;
    end
  end

`ifdef COLL_EVENT_FIFO_EN
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [IW-1:0] mem_q [FIFO_DEPTH];
  logic [IW-1:0] mem_d [FIFO_DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          valid_q, valid_d;
  logic [IW-1:0] head_q, head_d;
  logic          full_c, push_c, pop_c;

  // Kill-event FIFO; a push into a full FIFO survives only if the head pops that cycle
  always_comb begin
    mem_d  = mem_q;
    rd_d   = rd_q;
    wr_d   = wr_q;
    cnt_d  = cnt_q;
    full_c = (cnt_q == CW'(FIFO_DEPTH));
    pop_c  = valid_q & evt_ready;
    push_c = kill_c & (~full_c | pop_c);
    drop_c = kill_c & full_c & ~pop_c;
    if (push_c) begin
      mem_d[wr_q] = kill_idx_c;
      wr_d        = wr_q + AW'(1);
    end
    if (pop_c) rd_d = rd_q + AW'(1);
    if (push_c && !pop_c)      cnt_d = cnt_q + CW'(1);
    else if (pop_c && !push_c) cnt_d = cnt_q - CW'(1);
    valid_d = (cnt_d != '0);
    head_d  = valid_d ? mem_d[rd_d] : '0;
  end

  // FIFO registers
  always_ff @(posedge pixel_clk) begin
    if (Reset) begin
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      head_q  <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      head_q  <= head_d;
      mem_q   <= mem_d;
    end
  end

  assign evt_valid = valid_q;
  assign evt_idx   = head_q;
`else
  logic unused_fifo;

  assign drop_c      = 1'b0;
  assign evt_valid   = 1'b0;
  assign evt_idx     = '0;
  assign unused_fifo = ^{evt_ready, kill_c, kill_idx_c, 1'(FIFO_DEPTH)};
`endif

  assign ShipColl  = ship_coll_q;
  assign ProjColl  = proj_coll_q;
  assign EProjColl = eproj_coll_q;
  assign alive     = alive_q;
  assign ExplodeOn = explode_q;
  assign evt_ovf   = ovf_q;

endmodule

// File: tb/tb_collision_manager.sv
// Self-checking bench for collision_manager: directed scenarios plus randomized frames,
// checked every cycle against a frame/event-level reference model.
module tb_collision_manager;
  localparam int NP    = 2;
  localparam int NE    = 8;
  localparam int NPE   = 2;
  localparam int HP_W  = 2;
  localparam int EXPL  = 16;
  localparam int DEPTH = 4;
  localparam int IW    = 3;
  localparam int EPW   = NE * NPE;

  logic              pixel_clk = 1'b0;
  logic              Reset = 1'b0;
  logic              frame_clk = 1'b0;
  logic              ShipOn = 1'b0;
  logic [NP-1:0]     ProjOn = '0;
  logic [NE-1:0]     EShipOn = '0;
  logic [EPW-1:0]    EProjOn = '0;
  logic [NE-1:0]     spawn = '0;
  logic [HP_W-1:0]   hp_init = '0;
  logic              ShipColl;
  logic [NP-1:0]     ProjColl;
  logic [EPW-1:0]    EProjColl;
  logic [NE-1:0]     alive;
  logic [NE-1:0]     ExplodeOn;
  logic              evt_valid;
  logic [IW-1:0]     evt_idx;
  logic              evt_ready = 1'b0;
  logic              evt_ovf;

  int vectors = 0;
  int miscompares = 0;

  collision_manager #(.NP(NP), .NE(NE), .NPE(NPE), .HP_W(HP_W),
                      .EXPL_FRAMES(EXPL), .FIFO_DEPTH(DEPTH)) dut (
    .pixel_clk(pixel_clk), .Reset(Reset), .frame_clk(frame_clk), .ShipOn(ShipOn),
    .ProjOn(ProjOn), .EShipOn(EShipOn), .EProjOn(EProjOn), .spawn(spawn),
    .hp_init(hp_init), .ShipColl(ShipColl), .ProjColl(ProjColl), .EProjColl(EProjColl),
    .alive(alive), .ExplodeOn(ExplodeOn), .evt_valid(evt_valid), .evt_idx(evt_idx),
    .evt_ready(evt_ready), .evt_ovf(evt_ovf));

  always #5 pixel_clk = ~pixel_clk;

  // Reference model: per-enemy records, frame accumulators, scan position and event queue
  int             m_hp [NE];
  int             m_timer [NE];
  logic [NE-1:0]  m_alive;
  logic [NE-1:0]  m_snap;
  int             scan_pos;
  int             q[$];
  logic           m_ovf, m_fcq;
  logic           acc_ship, m_ship;
  logic [NP-1:0]  acc_proj, m_proj;
  logic [NE-1:0]  acc_esh;
  logic [EPW-1:0] acc_eproj, m_eproj;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NE; i++) begin m_hp[i] = 0; m_timer[i] = 0; end
    m_alive = '0; m_snap = '0; scan_pos = -1; q.delete();
    m_ovf = 1'b0; m_fcq = 1'b0;
    acc_ship = 1'b0; acc_proj = '0; acc_esh = '0; acc_eproj = '0;
    m_ship = 1'b0; m_proj = '0; m_eproj = '0;
  endtask

  // Advance the model across one clock edge using the inputs currently driven
  task automatic model_edge();
    logic fe;
    logic [NE-1:0] es, h_esh, n_alive;
    logic h_ship;
    logic [NP-1:0] h_proj;
    logic [EPW-1:0] h_eproj;
    int n_hp [NE];
    int n_timer [NE];
    int kill, n_scan;
    if (Reset) begin model_reset(); return; end
    fe      = frame_clk & ~m_fcq;
    es      = EShipOn & m_alive;
    h_ship  = ShipOn && ((EProjOn != 0) || (es != 0));
    h_proj  = (es != 0) ? ProjOn : '0;
    h_esh   = (ProjOn != 0) ? es : '0;
    h_eproj = ShipOn ? EProjOn : '0;
    n_alive = m_alive; n_hp = m_hp; n_timer = m_timer;
    if (fe) for (int i = 0; i < NE; i++) if (n_timer[i] > 0) n_timer[i]--;
    kill = -1;
    n_scan = scan_pos;
    if (scan_pos >= 0) begin
      if (m_snap[scan_pos] && m_alive[scan_pos]) begin
        if (m_hp[scan_pos] > 1) n_hp[scan_pos] = m_hp[scan_pos] - 1;
        else begin
          n_hp[scan_pos] = 0; n_alive[scan_pos] = 1'b0;
          n_timer[scan_pos] = EXPL; kill = scan_pos;
        end
      end
      n_scan = (scan_pos == NE - 1) ? -1 : scan_pos + 1;
    end
    for (int i = 0; i < NE; i++) begin
      if (spawn[i]) begin
        n_alive[i] = 1'b1; n_hp[i] = (hp_init == 0) ? 1 : int'(hp_init); n_timer[i] = 0;
        if (kill == i) kill = -1;
      end
    end
    if (fe) begin
      if (scan_pos < 0) begin m_snap = acc_esh; n_scan = 0; end
      else m_ovf = 1'b1;
      m_ship = acc_ship; m_proj = acc_proj; m_eproj = acc_eproj;
      acc_ship = h_ship; acc_proj = h_proj; acc_esh = h_esh; acc_eproj = h_eproj;
    end else begin
      acc_ship |= h_ship; acc_proj |= h_proj; acc_esh |= h_esh; acc_eproj |= h_eproj;
    end
`ifdef COLL_EVENT_FIFO_EN
    if (q.size() > 0 && evt_ready) void'(q.pop_front());
    if (kill >= 0) begin
      if (q.size() < DEPTH) q.push_back(kill);
      else m_ovf = 1'b1;
    end
`endif
    m_alive = n_alive; m_hp = n_hp; m_timer = n_timer; scan_pos = n_scan;
    m_fcq = frame_clk;
  endtask

  task automatic check_all();
    logic [NE-1:0] m_expl;
    logic [36:0] obs, exp;
    for (int i = 0; i < NE; i++) m_expl[i] = (m_timer[i] > 0);
    obs = {ShipColl, ProjColl, EProjColl, alive, ExplodeOn, evt_valid, evt_ovf};
    exp = {m_ship, m_proj, m_eproj, m_alive, m_expl, (q.size() != 0), m_ovf};
    check("cycle_outputs", 64'(obs), 64'(exp));
`ifdef COLL_EVENT_FIFO_EN
    if (q.size() > 0) check("cycle_evt_idx", 64'(evt_idx), 64'(q[0]));
`else
    check("cycle_evt_idx_zero", 64'(evt_idx), 64'd0);
`endif
  endtask

  task automatic tick();
    model_edge();
    @(posedge pixel_clk);
    #1;
    check_all();
  endtask

  task automatic clear_pix();
    ShipOn = 1'b0; ProjOn = '0; EShipOn = '0; EProjOn = '0; spawn = '0;
  endtask

  task automatic idle(input int n);
    clear_pix();
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic fe_tick();
    clear_pix(); frame_clk = 1'b1; tick(); frame_clk = 1'b0;
  endtask

  task automatic do_reset();
    clear_pix(); evt_ready = 1'b0; frame_clk = 1'b0;
    Reset = 1'b1; tick(); tick(); Reset = 1'b0;
  endtask

  task automatic spawn_set(input logic [NE-1:0] m, input logic [HP_W-1:0] h);
    clear_pix(); spawn = m; hp_init = h; tick(); spawn = '0;
  endtask

  task automatic hit(input logic [NE-1:0] e, input logic [NP-1:0] p);
    clear_pix(); EShipOn = e; ProjOn = p; tick(); clear_pix();
  endtask

  initial begin
    int hi, len;
    // reset state
    do_reset();
    check("reset_outputs",
          64'({ShipColl, ProjColl, EProjColl, alive, ExplodeOn, evt_valid, evt_ovf}), 64'd0);

    // kill enemy 3 with two hits over two frames
    spawn_set(8'h08, 2'd2);
    hit(8'h08, 2'b01);
    fe_tick();
    check("kill_projcoll_f1", 64'(ProjColl), 64'd1);
    idle(NE + 4);
    check("kill_alive_after_f1", 64'(alive[3]), 64'd1);
    hit(8'h08, 2'b01);
    fe_tick();
    idle(3);
    check("kill_alive_at_fe4", 64'(alive[3]), 64'd1);
    idle(1);
    check("kill_alive_at_fe5", 64'(alive[3]), 64'd0);
    check("kill_explode_at_fe5", 64'(ExplodeOn[3]), 64'd1);
`ifdef COLL_EVENT_FIFO_EN
    check("kill_evt_valid", 64'(evt_valid), 64'd1);
    check("kill_evt_idx", 64'(evt_idx), 64'd3);
`else
    check("kill_evt_valid_off", 64'(evt_valid), 64'd0);
`endif
    for (int i = 1; i <= EXPL; i++) begin
      fe_tick();
      check("explode_frames", 64'(ExplodeOn[3]), (i < EXPL) ? 64'd1 : 64'd0);
      idle(NE + 2);
    end

    // one-pixel ship hit by enemy projectile bit 5
    do_reset();
    clear_pix(); ShipOn = 1'b1; EProjOn = 16'h0020; tick(); clear_pix();
    idle(3);
    fe_tick();
    check("ship_coll_set", 64'(ShipColl), 64'd1);
    check("eproj_coll_set", 64'(EProjColl), 64'h20);
    idle(5);
    check("eproj_coll_hold", 64'(EProjColl), 64'h20);
    fe_tick();
    check("ship_coll_clear", 64'(ShipColl), 64'd0);
    check("eproj_coll_clear", 64'(EProjColl), 64'd0);

    // dead enemy: hp_init 0 acts as 1, later overlaps are ignored
    do_reset();
    spawn_set(8'h04, 2'd0);
    hit(8'h04, 2'b10);
    fe_tick();
    idle(NE + 4);
    check("dead_alive", 64'(alive[2]), 64'd0);
    evt_ready = 1'b1;
    idle(2);
    hit(8'h04, 2'b01);
    fe_tick();
    check("dead_projcoll", 64'(ProjColl), 64'd0);
    idle(NE + 4);
    check("dead_no_event", 64'(evt_valid), 64'd0);
    evt_ready = 1'b0;

    // back-pressure: five kills into a depth-4 FIFO
    do_reset();
    spawn_set(8'h1F, 2'd1);
    hit(8'h1F, 2'b01);
    fe_tick();
    idle(NE + 4);
    check("bp_alive", 64'(alive), 64'd0);
`ifdef COLL_EVENT_FIFO_EN
    check("bp_ovf", 64'(evt_ovf), 64'd1);
    evt_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      check("bp_order", 64'(evt_idx), 64'(j));
      tick();
    end
    check("bp_empty", 64'(evt_valid), 64'd0);
    evt_ready = 1'b0;
`else
    check("bp_ovf_off", 64'(evt_ovf), 64'd0);
`endif

    // full FIFO with a pop in the push cycle
    do_reset();
    spawn_set(8'h2F, 2'd1);
    hit(8'h0F, 2'b01);
    fe_tick();
    idle(NE + 4);
    hit(8'h20, 2'b01);
    fe_tick();
    idle(5);
    evt_ready = 1'b1; tick(); evt_ready = 1'b0;
    check("fp_ovf", 64'(evt_ovf), 64'd0);
`ifdef COLL_EVENT_FIFO_EN
    evt_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      check("fp_order", 64'(evt_idx), (j == 3) ? 64'd5 : 64'(j + 1));
      tick();
    end
    check("fp_empty", 64'(evt_valid), 64'd0);
    evt_ready = 1'b0;
`endif

    // reset while the scan sits at k = 4
    do_reset();
    spawn_set(8'hFF, 2'd1);
    clear_pix(); ShipOn = 1'b1; EShipOn = 8'hFF; ProjOn = 2'b11; tick(); clear_pix();
    fe_tick();
    idle(4);
    Reset = 1'b1; tick(); Reset = 1'b0;
    check("rst_scan_outputs",
          64'({ShipColl, ProjColl, EProjColl, alive, ExplodeOn, evt_valid, evt_ovf}), 64'd0);
    idle(NE + 2);
    check("rst_scan_quiet", 64'(evt_valid), 64'd0);

    // randomized frames, including occasional frames too short for a full scan
    do_reset();
    for (int f = 0; f < 60; f++) begin
      hi  = $urandom_range(1, 3);
      len = ($urandom_range(0, 7) == 0) ? $urandom_range(hi + 1, NE) : $urandom_range(NE + 2, NE + 24);
      for (int c = 0; c < len; c++) begin
        frame_clk = (c < hi);
        ShipOn    = ($urandom_range(0, 5) == 0);
        ProjOn    = 2'($urandom) & 2'($urandom);
        EShipOn   = 8'($urandom) & 8'($urandom);
        EProjOn   = 16'($urandom) & 16'($urandom) & 16'($urandom);
        spawn     = ($urandom_range(0, 15) == 0) ? 8'(1 << $urandom_range(0, NE - 1)) : 8'h00;
        hp_init   = 2'($urandom_range(0, 3));
        evt_ready = ($urandom_range(0, 2) != 0);
        tick();
      end
    end
    clear_pix(); frame_clk = 1'b0;
    idle(NE + 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
